// File: rtl/out_act_regfile.sv
// out_act_regfile: per-PE output-activation register file.
// Write-back port from the add stage, one registered read port for the mult stage
// with write-first and output-forward bypasses, and a clear/drain sequencer.
// Optional feature macro: OUT_ACT_RELU_EN (zeroes negative values on the drain port only).
module out_act_regfile #(
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4,
   parameter int ACT_W  = 24
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [ACT_W-1:0]  rd_data,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [ACT_W-1:0]  wr_data,
   input  logic              clr_start,
   input  logic              drain_start,
   output logic              busy,
   output logic              drain_valid,
   input  logic              drain_ready,
   output logic [ADDR_W-1:0] drain_addr,
   output logic [ACT_W-1:0]  drain_data
);

   typedef enum logic [1:0] {IDLE, CLEAR, DRAIN} state_t;

   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

   logic [ACT_W-1:0]  mem [DEPTH];
   state_t            state_q;
   logic [ADDR_W-1:0] cnt_q;
   logic              busy_q;
   logic              drain_valid_q;
   logic [ADDR_W-1:0] drain_addr_q;
   logic [ACT_W-1:0]  drain_data_q;
   logic [ADDR_W-1:0] rd_addr_q;
   logic [ACT_W-1:0]  mem_q;

   logic              drain_hs;
   logic [ADDR_W-1:0] drain_sel_d;
   logic [ACT_W-1:0]  drain_raw_d;
   logic [ACT_W-1:0]  drain_val_d;

   assign drain_hs = drain_valid_q & drain_ready;

`ifdef OUT_ACT_RELU_EN
   // Drained values are rectified; the stored array keeps the raw sum
   assign drain_val_d = drain_raw_d[ACT_W-1] ? '0 : drain_raw_d;
`else
   assign drain_val_d = drain_raw_d;
`endif

   // Select the entry to present next on the drain port, forwarding a same-cycle write
   always_comb begin
      drain_sel_d = cnt_q;
      if (state_q == IDLE) begin
         drain_sel_d = '0;
      end else if (state_q == DRAIN && drain_hs) begin
         drain_sel_d = cnt_q + 1'b1;
      end
      drain_raw_d = (wr_en && wr_addr == drain_sel_d) ? wr_data : mem[drain_sel_d];
   end

   // Array writes: clear write first, so an upstream write to the same entry wins
   always_ff @(posedge clk) begin
      if (state_q == CLEAR) begin
         mem[cnt_q] <= '0;
      end
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // Registered read with write-first bypass; rd_en low holds the previous result
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_addr_q <= '0;
         mem_q     <= '0;
      end else if (rd_en) begin
         rd_addr_q <= rd_addr;
         mem_q     <= (wr_en && wr_addr == rd_addr) ? wr_data : mem[rd_addr];
      end
   end

   // Output forward: a write landing on the address just read replaces the stale value
   assign rd_data = (wr_en && wr_addr == rd_addr_q) ? wr_data : mem_q;

   // Clear/drain sequencer with registered status and drain outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         busy_q        <= 1'b0;
         drain_valid_q <= 1'b0;
         drain_addr_q  <= '0;
         drain_data_q  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (clr_start) begin
                  state_q <= CLEAR;
                  busy_q  <= 1'b1;
                  cnt_q   <= '0;
               end else if (drain_start) begin
                  state_q       <= DRAIN;
                  busy_q        <= 1'b1;
                  cnt_q         <= '0;
                  drain_valid_q <= 1'b1;
                  drain_addr_q  <= '0;
                  drain_data_q  <= drain_val_d;
               end
            end
            CLEAR: begin
               // cnt wraps back to 0 after the last entry
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == LAST) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
            end
            DRAIN: begin
               if (drain_hs) begin
                  if (cnt_q == LAST) begin
                     state_q       <= IDLE;
                     busy_q        <= 1'b0;
                     drain_valid_q <= 1'b0;
                     cnt_q         <= '0;
                  end else begin
                     cnt_q        <= cnt_q + 1'b1;
                     drain_addr_q <= cnt_q + 1'b1;
                     drain_data_q <= drain_val_d;
                  end
               end else begin
                  // Stalled: refresh so a write to the presented entry shows up
                  drain_data_q <= drain_val_d;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign busy        = busy_q;
   assign drain_valid = drain_valid_q;
   assign drain_addr  = drain_addr_q;
   assign drain_data  = drain_data_q;

endmodule
